// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame parameters,
// used by both rx_uart and tx_uart.
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int N_TICKS_DEF   = 16;
    localparam int SB_TICKS_DEF  = 16;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is
// chosen so the output shows the input's inactive level straight out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] sync_q;

    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], i_d};
        end
    end

    assign o_q = sync_q[1];

endmodule

// File: rtl/rx_uart.sv
// UART receiver: oversampled start/data/stop framing with a one-clock done
// strobe, held data word and framing-error flag.
module rx_uart
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int N_TICKS   = N_TICKS_DEF,
    parameter int SB_TICKS  = SB_TICKS_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ticks,
    input  logic                 i_data_in,
    output logic                 o_rx_done,
    output logic [DATA_BITS-1:0] o_data_out,
    output logic                 o_frame_error
);

    localparam int S_W = $clog2(max_int(N_TICKS, SB_TICKS));
    localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [S_W-1:0] S_HALF = S_W'(N_TICKS / 2 - 1);
    localparam logic [S_W-1:0] S_BIT  = S_W'(N_TICKS - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICKS - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic [1:0]           state,       state_n;
    logic [S_W-1:0]       s_cnt,       s_cnt_n;
    logic [N_W-1:0]       n_cnt,       n_cnt_n;
    logic [DATA_BITS-1:0] shift,       shift_n;
    logic [DATA_BITS-1:0] data_q,      data_n;
    logic                 frame_err_q, frame_err_n;
    logic                 done_q,      done_n;

    // Line idles high, so the synchroniser comes out of reset reading "idle".
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_data_in),
        .o_q     (rx_s)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_IDLE;
            s_cnt       <= '0;
            n_cnt       <= '0;
            shift       <= '0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_n;
            s_cnt       <= s_cnt_n;
            n_cnt       <= n_cnt_n;
            shift       <= shift_n;
            data_q      <= data_n;
            frame_err_q <= frame_err_n;
            done_q      <= done_n;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves a signal unassigned and no latch is inferred.
        state_n     = state;
        s_cnt_n     = s_cnt;
        n_cnt_n     = n_cnt;
        shift_n     = shift;
        data_n      = data_q;
        frame_err_n = frame_err_q;
        done_n      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n = ST_START;
                    s_cnt_n = '0;
                end
            end
            ST_START: begin
                if (i_ticks) begin
                    if (s_cnt == S_HALF) begin
                        // A start bit that has gone high again by mid-bit was a glitch.
                        if (!rx_s) begin
                            state_n = ST_DATA;
                            s_cnt_n = '0;
                            n_cnt_n = '0;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        s_cnt_n = s_cnt + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (i_ticks) begin
                    if (s_cnt == S_BIT) begin
                        shift_n = DATA_BITS'({rx_s, shift} >> 1);
                        s_cnt_n = '0;
                        if (n_cnt == N_LAST) begin
                            state_n = ST_STOP;
                        end else begin
                            n_cnt_n = n_cnt + N_W'(1);
                        end
                    end else begin
                        s_cnt_n = s_cnt + S_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (i_ticks) begin
                    if (s_cnt == S_STOP) begin
                        state_n     = ST_IDLE;
                        data_n      = shift;
                        frame_err_n = ~rx_s;
                        done_n      = 1'b1;
                    end else begin
                        s_cnt_n = s_cnt + S_W'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign o_rx_done     = done_q;
    assign o_data_out    = data_q;
    assign o_frame_error = frame_err_q;

endmodule

// File: tb/tb_rx_uart.sv
// Self-checking bench for rx_uart: a serial line model feeds frames, and a
// scoreboard of expected {word, framing error} is compared on every done strobe.
module tb_rx_uart;
    import uart_pkg::*;

    localparam int TICK_DIV = 4;                 // clocks per oversampling tick
    localparam int BIT_CLKS = N_TICKS_DEF * TICK_DIV;
    localparam int FRAME_CLKS = BIT_CLKS * 10;
    localparam int N_LOOP = 32;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         gap_bits;
        logic [7:0] exp_data;
        logic       exp_fe;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       fe;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       ticks;
    logic       line;
    logic       rx_done;
    logic [7:0] data_out;
    logic       frame_error;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic prev_done = 1'b0;
    int   tick_cnt = 0;

    rx_uart #(
        .DATA_BITS (8),
        .N_TICKS   (N_TICKS_DEF),
        .SB_TICKS  (SB_TICKS_DEF)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_ticks       (ticks),
        .i_data_in     (line),
        .o_rx_done     (rx_done),
        .o_data_out    (data_out),
        .o_frame_error (frame_error)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Baud tick model: one-clock strobe every TICK_DIV clocks, changed away from posedge.
    initial begin
        ticks = 1'b0;
        forever begin
            @(negedge clk);
            ticks    = (tick_cnt == TICK_DIV - 1);
            tick_cnt = (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every done strobe must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_done === 1'b1) begin
                check("done_width", {31'd0, prev_done}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done data=%0h fe=%0b t=%0t", data_out, frame_error, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rx_data", {24'd0, data_out}, {24'd0, e.data});
                    check("rx_fe", {31'd0, frame_error}, {31'd0, e.fe});
                end
            end
            prev_done = rx_done;
        end
    end

    task automatic drive_bit(input logic v, input int clks);
        line = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int gap_bits);
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
        // A low stop bit is cut short so the line is high again before the
        // receiver's re-armed start check lands half a bit later.
        if (stop_bit) drive_bit(1'b1, BIT_CLKS);
        else          drive_bit(1'b0, BIT_CLKS * 3 / 4);
        drive_bit(1'b1, gap_bits * BIT_CLKS);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, sb.size(), 32'd0);
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, gap_bits: 2, exp_data: 8'hA5, exp_fe: 1'b0};
        vecs[1] = '{data: 8'h3C, stop_bit: 1'b0, gap_bits: 2, exp_data: 8'h3C, exp_fe: 1'b1};
        vecs[2] = '{data: 8'h00, stop_bit: 1'b1, gap_bits: 0, exp_data: 8'h00, exp_fe: 1'b0};
        vecs[3] = '{data: 8'hFF, stop_bit: 1'b1, gap_bits: 2, exp_data: 8'hFF, exp_fe: 1'b0};

        line  = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_done",  {31'd0, rx_done}, 32'd0);
        check("rst_data",  {24'd0, data_out}, 32'd0);
        check("rst_fe",    {31'd0, frame_error}, 32'd0);
        check("rst_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
        rst_n = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);

        // Table vectors: normal frame, low stop bit, back-to-back 00/FF.
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{data: vecs[i].exp_data, fe: vecs[i].exp_fe});
            send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].gap_bits);
        end
        wait_drain("drain_table", 4 * FRAME_CLKS);

        // Short low glitch must be rejected at mid start bit.
        drive_bit(1'b0, 3 * TICK_DIV);
        drive_bit(1'b1, 2 * BIT_CLKS);
        check("glitch_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
        check("glitch_sb",    sb.size(), 32'd0);
        sb.push_back('{data: 8'h5A, fe: 1'b0});
        send_frame(8'h5A, 1'b1, 2);
        wait_drain("drain_5a", 2 * FRAME_CLKS);

        // Reset in data bit 4 of 0xC3 clears outputs without a clock edge.
        check("pre_rst_data", {24'd0, data_out}, 32'h5A);
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(logic'(8'hC3 >> i), BIT_CLKS);
        line = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_data",  {24'd0, data_out}, 32'd0);
        check("async_rst_fe",    {31'd0, frame_error}, 32'd0);
        check("async_rst_done",  {31'd0, rx_done}, 32'd0);
        check("async_rst_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
        line = 1'b1;
        repeat (FRAME_CLKS) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("post_rst_sb", sb.size(), 32'd0);
        sb.push_back('{data: 8'h81, fe: 1'b0});
        send_frame(8'h81, 1'b1, 2);
        wait_drain("drain_81", 2 * FRAME_CLKS);

        // Random loopback traffic with 0 or 1 idle bits between frames.
        for (int i = 0; i < N_LOOP; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            sb.push_back('{data: b, fe: 1'b0});
            send_frame(b, 1'b1, int'($urandom_range(0, 1)));
        end
        wait_drain("drain_loop", 2 * FRAME_CLKS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
